// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Optional watchdog on the busy handshakes: define SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int RX_SETTLE = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             cfg_cpol_i,
  input  logic [NUM_REQ-1:0]             cfg_cpha_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   txdata_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic [NUM_REQ-1:0]             err_o,
  output logic [DATA_SIZE-1:0]           rxdata_o,
  output logic                           spi_start_o,
  output logic                           spi_cpol_o,
  output logic                           spi_cpha_o,
  output logic [DATA_SIZE-1:0]           spi_txdata_o,
  input  logic                           spi_busy_i,
  input  logic [DATA_SIZE-1:0]           spi_rxdata_i,
  output logic [NUM_REQ-1:0]             cs_n_o
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(RX_SETTLE + 1);

  typedef enum logic [6:0] {
    IDLE      = 7'b0000001,
    SETUP     = 7'b0000010,
    LAUNCH    = 7'b0000100,
    WAIT_BUSY = 7'b0001000,
    WAIT_IDLE = 7'b0010000,
    SETTLE    = 7'b0100000,
    DONE      = 7'b1000000
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, idx, sel, cand;
  logic            found;
  logic [SW-1:0]   settle_cnt;
  logic            tmo_hit, timed_out;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                       tmo_cnt <= '0;
    else if (state_nx != state)                       tmo_cnt <= '0;
    else if (state == WAIT_BUSY || state == WAIT_IDLE) tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
  assign timed_out = (state == WAIT_BUSY || state == WAIT_IDLE) && (state_nx == DONE);
`else
  assign tmo_hit   = 1'b0;
  assign timed_out = 1'b0;
`endif

  // Search starts just after the last served requester, wrapping around.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(ptr) + i + 1) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (found) state_nx = SETUP;
      SETUP:     state_nx = LAUNCH;
      LAUNCH:    state_nx = WAIT_BUSY;
      WAIT_BUSY: if (spi_busy_i) state_nx = WAIT_IDLE;
                 else if (tmo_hit) state_nx = DONE;
      WAIT_IDLE: if (!spi_busy_i) state_nx = SETTLE;
                 else if (tmo_hit) state_nx = DONE;
      SETTLE:    if (settle_cnt == '0) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Chip-select follows the master's busy combinationally.
  always_comb begin
    cs_n_o = '1;
    if (state == WAIT_BUSY || state == WAIT_IDLE || state == SETTLE)
      cs_n_o[idx] = ~spi_busy_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_o        <= '0;
      done_o       <= '0;
      err_o        <= '0;
      rxdata_o     <= '0;
      spi_start_o  <= 1'b0;
      spi_cpol_o   <= 1'b0;
      spi_cpha_o   <= 1'b0;
      spi_txdata_o <= '0;
      ptr          <= IW'(NUM_REQ - 1);
      idx          <= '0;
      settle_cnt   <= '0;
    end else begin
      // Outputs are registered from the next state so they line up with it.
      spi_start_o <= (state_nx == WAIT_BUSY);
      done_o      <= '0;
      err_o       <= '0;
      if (state_nx == DONE) begin
        done_o <= gnt_o;
        if (timed_out) begin
          err_o    <= gnt_o;
          rxdata_o <= '1;
        end
      end
      case (state)
        IDLE: if (found) begin
          idx          <= sel;
          gnt_o        <= NUM_REQ'(1) << sel;
          spi_cpol_o   <= cfg_cpol_i[sel];
          spi_cpha_o   <= cfg_cpha_i[sel];
          spi_txdata_o <= txdata_i[sel*DATA_SIZE +: DATA_SIZE];
        end
        WAIT_IDLE: if (!spi_busy_i) settle_cnt <= SW'(RX_SETTLE - 1);
        SETTLE: begin
          if (settle_cnt == '0) rxdata_o <= spi_rxdata_i;
          else                  settle_cnt <= settle_cnt - SW'(1);
        end
        DONE: begin
          gnt_o <= '0;
          ptr   <= idx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized scoreboard bench for spi_txn_arbiter with a behavioural SPI slave/master model.
module tb_spi_txn_arbiter;
  localparam int NR = 4;
  localparam int DS = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [NR-1:0] req_i, cfg_cpol_i, cfg_cpha_i;
  logic [NR*DS-1:0] txdata_i;
  logic [NR-1:0] gnt_o, done_o, err_o, cs_n_o;
  logic [DS-1:0] rxdata_o, spi_txdata_o, spi_rxdata_i;
  logic          spi_start_o, spi_cpol_o, spi_cpha_o, spi_busy_i;

  spi_txn_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DS), .RX_SETTLE(4), .TIMEOUT(20)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .cfg_cpol_i(cfg_cpol_i), .cfg_cpha_i(cfg_cpha_i),
    .txdata_i(txdata_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rxdata_o(rxdata_o),
    .spi_start_o(spi_start_o), .spi_cpol_o(spi_cpol_o), .spi_cpha_o(spi_cpha_o),
    .spi_txdata_o(spi_txdata_o), .spi_busy_i(spi_busy_i), .spi_rxdata_i(spi_rxdata_i),
    .cs_n_o(cs_n_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic       err;
    logic [7:0] rx;
    bit         use_rxq;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] rxq[$];
  int tests = 0, fails = 0;
  int mptr = NR - 1;
  bit stuck = 0, fixed_rx_en = 0;
  logic [7:0] fixed_rx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int p);
    for (int i = 1; i <= NR; i++) begin
      int j;
      j = (p + i) % NR;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic push_phase(input logic [NR-1:0] r, input int k);
    exp_t e;
    for (int n = 0; n < k; n++) begin
      e.idx = rr_pick(r, mptr);
      e.cpol = cfg_cpol_i[e.idx];
      e.cpha = cfg_cpha_i[e.idx];
      e.tx = txdata_i[e.idx*DS +: DS];
      e.err = 1'b0;
      e.rx = 8'h00;
      e.use_rxq = 1'b1;
      mptr = e.idx;
      expq.push_back(e);
    end
  endtask

  // Slave/master model: detects start two cycles late, holds busy, returns a word.
  initial begin
    int dly, len;
    logic prev;
    dly = 0; len = 0; prev = 1'b0;
    spi_busy_i = 1'b0;
    spi_rxdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_i) begin
        spi_busy_i = 1'b0; dly = 0; len = 0; prev = 1'b0;
      end else begin
        if (spi_busy_i) begin
          len--;
          if (len == 0) begin
            spi_busy_i = 1'b0;
            spi_rxdata_i = fixed_rx_en ? fixed_rx : 8'($urandom);
            rxq.push_back(spi_rxdata_i);
          end
        end else if (dly > 0) begin
          dly--;
          if (dly == 0) begin
            spi_busy_i = 1'b1;
            len = $urandom_range(3, 8);
          end
        end else if (!stuck && spi_start_o && !prev) begin
          dly = 2;
        end
        prev = spi_start_o;
      end
    end
  end

  // Monitor: compares every grant, busy window and done pulse against the scoreboard.
  initial begin
    logic [NR-1:0] prev_gnt, oh, exp_cs;
    logic prev_start;
    int low_run, gnt_due;
    logic [7:0] erx;
    exp_t e;
    prev_gnt = '0; prev_start = 1'b0; low_run = 0; gnt_due = -10;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        if (cyc == gnt_due - 1) check("gap_after_done", gnt_o, 0);
        if (cyc == gnt_due)     check("b2b_grant", gnt_o != 0, 1);
        if (gnt_o != 0 && prev_gnt == 0) begin
          if (expq.size() == 0) check("unexpected_grant", gnt_o, 0);
          else begin
            e = expq[0];
            oh = NR'(1) << e.idx;
            check("grant", gnt_o, oh);
            check("grant_mode_tx", {spi_cpol_o, spi_cpha_o, spi_txdata_o}, {e.cpol, e.cpha, e.tx});
          end
        end
        if (spi_busy_i && expq.size() > 0) begin
          e = expq[0];
          oh = NR'(1) << e.idx;
          exp_cs = ~oh;
          check("cs_n_busy", cs_n_o, exp_cs);
          check("mode_stable", {spi_cpol_o, spi_cpha_o, spi_txdata_o}, {e.cpol, e.cpha, e.tx});
        end else if (!spi_busy_i) begin
          check("cs_n_idle", cs_n_o, 4'hF);
        end
        if (spi_start_o && !prev_start) check("start_low_gap", low_run >= 2, 1);
        if (done_o != 0) begin
          if (expq.size() == 0) check("unexpected_done", done_o, 0);
          else begin
            e = expq.pop_front();
            oh = NR'(1) << e.idx;
            erx = e.rx;
            if (e.use_rxq) begin
              if (rxq.size() == 0) check("rx_available", 0, 1);
              else erx = rxq.pop_front();
            end
            check("done", done_o, oh);
            check("err", err_o, e.err ? oh : 4'h0);
            check("rxdata", rxdata_o, erx);
            if (expq.size() > 0) gnt_due = cyc + 2;
          end
        end else if (err_o != 0) begin
          check("err_without_done", err_o, 0);
        end
      end
      if (!spi_start_o) low_run++; else low_run = 0;
      prev_start = spi_start_o;
      prev_gnt = gnt_o;
    end
  end

  task automatic run_phase(input logic [NR-1:0] r, input int k, input bit drop_after_gnt,
                           input bit timing);
    int nd, guard, c;
    nd = 0; guard = 0;
    push_phase(r, k);
    @(negedge clk);
    req_i = r;
    c = cyc;
    if (timing) begin
      @(negedge clk); check("gnt_latency", {cyc - c, gnt_o}, {32'(1), r});
      @(negedge clk); check("start_low_setup", spi_start_o, 0);
      @(negedge clk); check("start_latency", {cyc - c, 31'd0, spi_start_o}, {32'(3), 32'(1)});
    end
    if (drop_after_gnt) begin
      while (gnt_o == 0 && guard < 100) begin @(negedge clk); guard++; end
      req_i = '0;
      cfg_cpol_i = ~cfg_cpol_i;
      cfg_cpha_i = ~cfg_cpha_i;
      txdata_i = ~txdata_i;
    end
    while (nd < k && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (done_o != 0) nd++;
    end
    req_i = '0;
    check("phase_dones", nd, k);
    repeat (4) @(negedge clk);
    check("queue_drained", expq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_i = 1'b0;
    #1;
    check("rst_gnt_done_err", {gnt_o, done_o, err_o}, 12'h000);
    check("rst_spi", {spi_start_o, spi_cpol_o, spi_cpha_o, spi_txdata_o, rxdata_o}, 19'h0);
    check("rst_cs_n", cs_n_o, 4'hF);
    expq.delete();
    rxq.delete();
    mptr = NR - 1;
    repeat (3) @(negedge clk);
    #2 rst_i = 1'b1;
  endtask

  initial begin
    int guard, s;
    exp_t e;
    rst_i = 1'b0; req_i = '0; cfg_cpol_i = '0; cfg_cpha_i = '0; txdata_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {gnt_o, done_o, err_o, spi_start_o, spi_cpol_o, spi_cpha_o}, 0);
    check("reset_data", {rxdata_o, spi_txdata_o}, 0);
    check("reset_cs_n", cs_n_o, 4'hF);
    #2 rst_i = 1'b1;

    // Single request from requester 1.
    cfg_cpol_i = 4'b0010; cfg_cpha_i = 4'b0000; txdata_i = 32'h00_00_A5_00;
    fixed_rx_en = 1; fixed_rx = 8'h3C;
    run_phase(4'b0010, 1, 0, 1);
    check("rx_hold", rxdata_o, 8'h3C);
    fixed_rx_en = 0;

    // Mode switching between (0,0) and (1,1).
    cfg_cpol_i = 4'b0010; cfg_cpha_i = 4'b0010; txdata_i = $urandom;
    run_phase(4'b0011, 4, 0, 0);

    for (int p = 0; p < 10; p++) begin
      cfg_cpol_i = 4'($urandom); cfg_cpha_i = 4'($urandom); txdata_i = $urandom;
      run_phase(4'($urandom_range(1, 15)), $urandom_range(1, 5), 0, 0);
    end

    // Request dropped after grant, inputs scrambled mid-transfer.
    cfg_cpol_i = 4'($urandom); cfg_cpha_i = 4'($urandom); txdata_i = $urandom;
    run_phase(4'b1000, 1, 1, 0);

    // Reset while waiting for busy to fall.
    cfg_cpol_i = 4'($urandom); cfg_cpha_i = 4'($urandom); txdata_i = $urandom;
    push_phase(4'b0100, 1);
    @(negedge clk); req_i = 4'b0100;
    guard = 0;
    while (!(spi_busy_i && !spi_start_o) && guard < 100) begin @(negedge clk); guard++; end
    check("reached_wait_idle", guard < 100, 1);
    req_i = '0;
    do_reset();

    // Contention after reset: order 0,1,2,3,0.
    cfg_cpol_i = 4'($urandom); cfg_cpha_i = 4'($urandom); txdata_i = $urandom;
    run_phase(4'b1111, 5, 0, 0);

    // Master never raises busy.
    stuck = 1;
    cfg_cpol_i = 4'($urandom); cfg_cpha_i = 4'($urandom); txdata_i = $urandom;
    push_phase(4'b0100, 1);
    e = expq.pop_back();
    e.err = 1'b1; e.rx = 8'hFF; e.use_rxq = 1'b0;
    expq.push_back(e);
    @(negedge clk); req_i = 4'b0100;
    guard = 0;
    while (!spi_start_o && guard < 100) begin @(negedge clk); guard++; end
    check("stuck_start_seen", spi_start_o, 1);
    s = cyc;
`ifdef SPI_ARB_TIMEOUT_EN
    guard = 0;
    while (done_o == 0 && guard < 60) begin @(negedge clk); guard++; end
    req_i = '0;
    check("timeout_latency", cyc - s, 20);
    check("timeout_start_dropped", spi_start_o, 0);
    repeat (3) @(negedge clk);
    check("timeout_queue_drained", expq.size(), 0);
`else
    repeat (40) begin
      @(negedge clk);
      check("stuck_hold", {spi_start_o, done_o, err_o}, {1'b1, 8'h00});
    end
    req_i = '0;
`endif
    stuck = 0;
    do_reset();

    cfg_cpol_i = 4'($urandom); cfg_cpha_i = 4'($urandom); txdata_i = $urandom;
    run_phase(4'($urandom_range(1, 15)), 3, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end
endmodule
